// File: rtl/uart_prog_loader.sv
// UART bootloader: receives 8N1 bytes, parses {target, 16-bit word count} header and
// writes little-endian DATA_W-bit words into instruction ROM or data RAM via upg_* strobes.
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 87,
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              rx_i,
    output logic              upg_wen_o,
    output logic [ADDR_W:0]   upg_adr_o,
    output logic [DATA_W-1:0] upg_dat_o,
    output logic              upg_busy_o,
    output logic              upg_done_o,
    output logic              upg_err_o
);
    localparam int BYTES  = DATA_W / 8;
    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    // Wide enough that a full 16-bit count never wraps back into the valid address range
    localparam int IDX_W  = ((ADDR_W > 16) ? ADDR_W : 16) + 1;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {L_IDLE, L_TGT, L_CNT0, L_CNT1, L_DATA, L_DONE} ld_state_t;

    // [0],[1] form the synchroniser; [2] is the previous synchronised value for edge detection
    logic [2:0] rx_sync_reg;
    logic       rx_line;
    logic       rx_fall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_sync_reg <= 3'b111;
        end else begin
            rx_sync_reg <= {rx_sync_reg[1:0], rx_i};
        end
    end

    assign rx_line = rx_sync_reg[1];
    assign rx_fall = rx_sync_reg[2] & ~rx_sync_reg[1];

    rx_state_t        rx_state_reg, rx_state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       rx_shift_reg, rx_shift_next;
    logic             byte_valid_reg, byte_valid_next;
    logic             frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state_reg   <= R_IDLE;
            bit_cnt_reg    <= '0;
            bit_idx_reg    <= '0;
            rx_shift_reg   <= '0;
            byte_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            rx_state_reg   <= rx_state_next;
            bit_cnt_reg    <= bit_cnt_next;
            bit_idx_reg    <= bit_idx_next;
            rx_shift_reg   <= rx_shift_next;
            byte_valid_reg <= byte_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        rx_state_next   = rx_state_reg;
        bit_cnt_next    = bit_cnt_reg + CNT_W'(1);
        bit_idx_next    = bit_idx_reg;
        rx_shift_next   = rx_shift_reg;
        byte_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        case (rx_state_reg)
            R_IDLE: begin
                bit_cnt_next = '0;
                bit_idx_next = '0;
                if (rx_fall) begin
                    rx_state_next = R_START;
                end
            end
            R_START: begin
                if (bit_cnt_reg == CNT_W'(CLKS_PER_BIT / 2 - 1)) begin
                    bit_cnt_next  = '0;
                    rx_state_next = rx_line ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (bit_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_next  = '0;
                    rx_shift_next = {rx_line, rx_shift_reg[7:1]};
                    bit_idx_next  = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        rx_state_next = R_STOP;
                    end
                end
            end
            R_STOP: begin
                if (bit_cnt_reg == CNT_W'(CLKS_PER_BIT - 1)) begin
                    bit_cnt_next    = '0;
                    byte_valid_next = rx_line;
                    frame_err_next  = ~rx_line;
                    rx_state_next   = R_IDLE;
                end
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    ld_state_t         state_reg, state_next;
    logic              target_reg, target_next;
    logic [15:0]       count_reg, count_next;
    logic [IDX_W-1:0]  word_idx_reg, word_idx_next;
    logic [LANE_W-1:0] lane_reg, lane_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic              start_prev_reg;
    logic              wen_reg, wen_next;
    logic [ADDR_W:0]   adr_reg, adr_next;
    logic [DATA_W-1:0] dat_reg, dat_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              err_reg, err_next;

    logic              start_edge;
    logic [DATA_W+7:0] shift_wide;
    logic [DATA_W-1:0] word_in;
    logic              overflow;
    logic              last_word;
    logic [15:0]       count_full;

    assign start_edge = start_i & ~start_prev_reg;
    assign shift_wide = {rx_shift_reg, data_reg};
    assign word_in    = shift_wide[DATA_W+7:8];
    assign overflow   = |(word_idx_reg >> ADDR_W);
    assign last_word  = (word_idx_reg + IDX_W'(1)) == IDX_W'(count_reg);
    assign count_full = {rx_shift_reg, count_reg[7:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= L_IDLE;
            target_reg     <= 1'b0;
            count_reg      <= '0;
            word_idx_reg   <= '0;
            lane_reg       <= '0;
            data_reg       <= '0;
            start_prev_reg <= 1'b0;
            wen_reg        <= 1'b0;
            adr_reg        <= '0;
            dat_reg        <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            target_reg     <= target_next;
            count_reg      <= count_next;
            word_idx_reg   <= word_idx_next;
            lane_reg       <= lane_next;
            data_reg       <= data_next;
            start_prev_reg <= start_i;
            wen_reg        <= wen_next;
            adr_reg        <= adr_next;
            dat_reg        <= dat_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        target_next   = target_reg;
        count_next    = count_reg;
        word_idx_next = word_idx_reg;
        lane_next     = lane_reg;
        data_next     = data_reg;
        wen_next      = 1'b0;
        adr_next      = adr_reg;
        dat_next      = dat_reg;
        busy_next     = busy_reg;
        done_next     = done_reg;
        err_next      = err_reg;
        case (state_reg)
            L_IDLE, L_DONE: begin
                if (start_edge) begin
                    state_next    = L_TGT;
                    busy_next     = 1'b1;
                    done_next     = 1'b0;
                    err_next      = 1'b0;
                    word_idx_next = '0;
                    lane_next     = '0;
                end
            end
            L_TGT: begin
                if (byte_valid_reg) begin
                    if (rx_shift_reg[7:1] == 7'd0) begin
                        target_next = rx_shift_reg[0];
                        state_next  = L_CNT0;
                    end else begin
                        err_next   = 1'b1;
                        busy_next  = 1'b0;
                        state_next = L_IDLE;
                    end
                end
            end
            L_CNT0: begin
                if (byte_valid_reg) begin
                    count_next = {8'd0, rx_shift_reg};
                    state_next = L_CNT1;
                end
            end
            L_CNT1: begin
                if (byte_valid_reg) begin
                    count_next = count_full;
                    if (count_full == 16'd0) begin
                        state_next = L_DONE;
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                    end else begin
                        state_next = L_DATA;
                    end
                end
            end
            L_DATA: begin
                if (byte_valid_reg) begin
                    data_next = word_in;
                    if (lane_reg == LANE_W'(BYTES - 1)) begin
                        lane_next = '0;
                        if (overflow) begin
                            err_next = 1'b1;
                        end else begin
                            wen_next = 1'b1;
                            adr_next = {target_reg, word_idx_reg[ADDR_W-1:0]};
                            dat_next = word_in;
                        end
                        word_idx_next = word_idx_reg + IDX_W'(1);
                        if (last_word) begin
                            state_next = L_DONE;
                            done_next  = 1'b1;
                            busy_next  = 1'b0;
                        end
                    end else begin
                        lane_next = lane_reg + LANE_W'(1);
                    end
                end
            end
            default: state_next = L_IDLE;
        endcase

        // A corrupted frame during a load abandons it; the host must restart
        if (frame_err_reg && (state_reg inside {L_TGT, L_CNT0, L_CNT1, L_DATA})) begin
            state_next = L_IDLE;
            err_next   = 1'b1;
            busy_next  = 1'b0;
            lane_next  = '0;
        end
    end

    assign upg_wen_o  = wen_reg;
    assign upg_adr_o  = adr_reg;
    assign upg_dat_o  = dat_reg;
    assign upg_busy_o = busy_reg;
    assign upg_done_o = done_reg;
    assign upg_err_o  = err_reg;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: drives 8N1 frames and checks strobes and status against a
// byte-stream parsing model.
module tb_uart_prog_loader;
    localparam int CLKS   = 16;
    localparam int ADDR_W = 3;
    localparam int DATA_W = 32;
    localparam int BYTES  = DATA_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start_i = 1'b0;
    logic              rx_i = 1'b1;
    logic              upg_wen_o;
    logic [ADDR_W:0]   upg_adr_o;
    logic [DATA_W-1:0] upg_dat_o;
    logic              upg_busy_o, upg_done_o, upg_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]        tx_bytes[$];
    logic [ADDR_W:0]   exp_adr[$], cap_adr[$];
    logic [DATA_W-1:0] exp_dat[$], cap_dat[$];
    logic              exp_done, exp_err, exp_busy;
    logic              st_busy, st_done, st_err;

    always #5 clk = ~clk;

    uart_prog_loader #(.CLKS_PER_BIT(CLKS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .rx_i(rx_i),
        .upg_wen_o(upg_wen_o), .upg_adr_o(upg_adr_o), .upg_dat_o(upg_dat_o),
        .upg_busy_o(upg_busy_o), .upg_done_o(upg_done_o), .upg_err_o(upg_err_o)
    );

    always @(negedge clk) begin
        if (upg_wen_o) begin
            cap_adr.push_back(upg_adr_o);
            cap_dat.push_back(upg_dat_o);
            $display("[TB] strobe adr=%h dat=%h", upg_adr_o, upg_dat_o);
        end
    end

    // Reference: parse the byte stream as header + words and list the writes it implies
    task automatic build_model();
        int n;
        int base;
        logic [DATA_W-1:0] w;
        exp_adr.delete();
        exp_dat.delete();
        exp_done = 1'b0;
        exp_err  = 1'b0;
        exp_busy = 1'b1;
        if (tx_bytes.size() == 0) return;
        if (tx_bytes[0] > 8'd1) begin
            exp_err  = 1'b1;
            exp_busy = 1'b0;
            return;
        end
        if (tx_bytes.size() < 3) return;
        n = int'(tx_bytes[1]) + 256 * int'(tx_bytes[2]);
        for (int k = 0; k < n; k++) begin
            base = 3 + k * BYTES;
            if (base + BYTES > tx_bytes.size()) return;
            for (int b = 0; b < BYTES; b++) w[8*b +: 8] = tx_bytes[base + b];
            if (k < DEPTH) begin
                exp_adr.push_back((ADDR_W+1)'(int'(tx_bytes[0]) * DEPTH + k));
                exp_dat.push_back(w);
            end else begin
                exp_err = 1'b1;
            end
        end
        exp_done = 1'b1;
        exp_busy = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop, input int gap);
        @(negedge clk) rx_i = 1'b0;
        repeat (CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CLKS) @(negedge clk);
        end
        rx_i = stop;
        repeat (CLKS) @(negedge clk);
        rx_i = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start_i = 1'b1;
        @(negedge clk);
        st_busy = upg_busy_o;
        st_done = upg_done_o;
        st_err  = upg_err_o;
        start_i = 1'b0;
    endtask

    task automatic send_all(input int max_gap);
        foreach (tx_bytes[i]) send_byte(tx_bytes[i], 1'b1, int'($urandom_range(0, max_gap)));
    endtask

    task automatic do_load(input int max_gap);
        build_model();
        cap_adr.delete();
        cap_dat.delete();
        pulse_start();
        send_all(max_gap);
        repeat (6) @(negedge clk);
    endtask

    task automatic random_image(input logic tgt, input int n);
        tx_bytes.delete();
        tx_bytes.push_back({7'd0, tgt});
        tx_bytes.push_back(8'(n));
        tx_bytes.push_back(8'(n >> 8));
        for (int i = 0; i < n * BYTES; i++) tx_bytes.push_back(8'($urandom));
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        n_tests++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_busy_o, upg_done_o, upg_err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got wen=%b adr=%h dat=%h busy=%b done=%b err=%b want all 0",
                     upg_wen_o, upg_adr_o, upg_dat_o, upg_busy_o, upg_done_o, upg_err_o);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_spec_vectors();
        for (int v = 0; v < 2; v++) begin
            if (v == 0) tx_bytes = '{8'h00, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
            else        tx_bytes = '{8'h01, 8'h01, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11};
            do_load(3);
            n_tests++;
            if (st_busy !== 1'b1 || st_done !== 1'b0 || st_err !== 1'b0) begin
                n_fail++;
                $display("FAIL spec%0d_start got busy=%b done=%b err=%b want 1 0 0", v, st_busy, st_done, st_err);
            end
            n_tests++;
            if (cap_adr.size() != exp_adr.size()) begin
                n_fail++;
                $display("FAIL spec%0d_count got %0d strobes want %0d", v, cap_adr.size(), exp_adr.size());
            end else begin
                foreach (exp_adr[i]) begin
                    n_tests++;
                    if (cap_adr[i] !== exp_adr[i] || cap_dat[i] !== exp_dat[i]) begin
                        n_fail++;
                        $display("FAIL spec%0d_word%0d got %h/%h want %h/%h", v, i, cap_adr[i], cap_dat[i], exp_adr[i], exp_dat[i]);
                    end
                end
            end
            n_tests++;
            if ({upg_busy_o, upg_done_o, upg_err_o} !== {exp_busy, exp_done, exp_err}) begin
                n_fail++;
                $display("FAIL spec%0d_status got busy/done/err=%b%b%b want %b%b%b", v,
                         upg_busy_o, upg_done_o, upg_err_o, exp_busy, exp_done, exp_err);
            end
        end
        n_tests++;
        if (cap_dat.size() != 1 || cap_dat[0] !== 32'h11223344 || cap_adr[0] !== 4'h8) begin
            n_fail++;
            $display("FAIL spec_literal got %0d strobes first %h want 1 strobe 8/11223344", cap_dat.size(), cap_dat[0]);
        end
    endtask

    task automatic test_random_loads(input string name, input int iters, input int max_n, input int max_gap);
        for (int it = 0; it < iters; it++) begin
            random_image(1'($urandom), int'($urandom_range(0, max_n)));
            do_load(max_gap);
            n_tests++;
            if (cap_adr.size() != exp_adr.size()) begin
                n_fail++;
                $display("FAIL %s%0d_count got %0d strobes want %0d", name, it, cap_adr.size(), exp_adr.size());
            end else begin
                foreach (exp_adr[i]) begin
                    n_tests++;
                    if (cap_adr[i] !== exp_adr[i] || cap_dat[i] !== exp_dat[i]) begin
                        n_fail++;
                        $display("FAIL %s%0d_word%0d got %h/%h want %h/%h", name, it, i, cap_adr[i], cap_dat[i], exp_adr[i], exp_dat[i]);
                    end
                end
            end
            n_tests++;
            if ({upg_busy_o, upg_done_o, upg_err_o} !== {exp_busy, exp_done, exp_err}) begin
                n_fail++;
                $display("FAIL %s%0d_status got %b%b%b want %b%b%b", name, it,
                         upg_busy_o, upg_done_o, upg_err_o, exp_busy, exp_done, exp_err);
            end
        end
    endtask

    task automatic test_overflow();
        random_image(1'b0, DEPTH + 3);
        do_load(1);
        n_tests++;
        if (cap_adr.size() != DEPTH || exp_adr.size() != DEPTH) begin
            n_fail++;
            $display("FAIL overflow_count got %0d strobes want %0d", cap_adr.size(), DEPTH);
        end else begin
            foreach (exp_adr[i]) begin
                n_tests++;
                if (cap_adr[i] !== exp_adr[i] || cap_dat[i] !== exp_dat[i]) begin
                    n_fail++;
                    $display("FAIL overflow_word%0d got %h/%h want %h/%h", i, cap_adr[i], cap_dat[i], exp_adr[i], exp_dat[i]);
                end
            end
        end
        n_tests++;
        if ({upg_busy_o, upg_done_o, upg_err_o} !== 3'b011) begin
            n_fail++;
            $display("FAIL overflow_status got %b%b%b want 011", upg_busy_o, upg_done_o, upg_err_o);
        end
    endtask

    task automatic test_zero_count();
        tx_bytes = '{8'h00, 8'h00, 8'h00};
        cap_adr.delete();
        cap_dat.delete();
        pulse_start();
        foreach (tx_bytes[i]) send_byte(tx_bytes[i], 1'b1, 0);
        n_tests++;
        if ({upg_busy_o, upg_done_o, upg_err_o} !== 3'b010 || cap_adr.size() != 0) begin
            n_fail++;
            $display("FAIL zero_count got busy/done/err=%b%b%b strobes=%0d want 010 and 0",
                     upg_busy_o, upg_done_o, upg_err_o, cap_adr.size());
        end
    endtask

    task automatic test_errors();
        cap_adr.delete();
        cap_dat.delete();
        pulse_start();
        send_byte(8'h00, 1'b1, 2);
        send_byte(8'h05, 1'b0, 2 * CLKS);
        n_tests++;
        if ({upg_busy_o, upg_done_o, upg_err_o} !== 3'b001 || cap_adr.size() != 0) begin
            n_fail++;
            $display("FAIL frame_err got busy/done/err=%b%b%b strobes=%0d want 001 and 0",
                     upg_busy_o, upg_done_o, upg_err_o, cap_adr.size());
        end
        random_image(1'b1, 1);
        do_load(2);
        n_tests++;
        if (st_err !== 1'b0 || st_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL err_clear got err=%b busy=%b want 0 1", st_err, st_busy);
        end
        tx_bytes = '{8'h07};
        do_load(2);
        n_tests++;
        if ({upg_busy_o, upg_done_o, upg_err_o} !== {exp_busy, exp_done, exp_err} || cap_adr.size() != 0) begin
            n_fail++;
            $display("FAIL bad_target got %b%b%b strobes=%0d want %b%b%b and 0",
                     upg_busy_o, upg_done_o, upg_err_o, cap_adr.size(), exp_busy, exp_done, exp_err);
        end
    endtask

    task automatic test_glitch_and_reset();
        tx_bytes = '{8'h00, 8'h01, 8'h00, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
        build_model();
        cap_adr.delete();
        cap_dat.delete();
        pulse_start();
        @(negedge clk) rx_i = 1'b0;
        repeat (CLKS / 4) @(negedge clk);
        rx_i = 1'b1;
        repeat (3 * CLKS) @(negedge clk);
        send_all(1);
        repeat (6) @(negedge clk);
        n_tests++;
        if (cap_adr.size() != 1 || cap_adr[0] !== exp_adr[0] || cap_dat[0] !== exp_dat[0] || upg_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL glitch got %0d strobes first %h/%h err=%b want 1 strobe %h/%h err=0",
                     cap_adr.size(), cap_adr[0], cap_dat[0], upg_err_o, exp_adr[0], exp_dat[0]);
        end
        cap_adr.delete();
        cap_dat.delete();
        pulse_start();
        for (int i = 0; i < 5; i++) send_byte(tx_bytes[i], 1'b1, 1);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({upg_wen_o, upg_adr_o, upg_dat_o, upg_busy_o, upg_done_o, upg_err_o} !== '0) begin
            n_fail++;
            $display("FAIL midload_reset got adr=%h dat=%h busy=%b done=%b err=%b want all 0",
                     upg_adr_o, upg_dat_o, upg_busy_o, upg_done_o, upg_err_o);
        end
        rst = 1'b1;
        send_byte(tx_bytes[5], 1'b1, 1);
        send_byte(tx_bytes[6], 1'b1, 6);
        n_tests++;
        if (cap_adr.size() != 0 || upg_busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL after_reset got %0d strobes busy=%b want 0 strobes busy=0", cap_adr.size(), upg_busy_o);
        end
        test_random_loads("fresh", 1, 3, 2);
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_random_loads("rand", 6, 4, 3);
        test_random_loads("b2b", 1, DEPTH, 0);
        test_overflow();
        test_zero_count();
        test_errors();
        test_glitch_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout got no completion want finish");
        $fatal(1, "timeout");
    end
endmodule
